// File: rtl/bus_grant_pkg.sv
// bus_grant_pkg: shared types for the bus grant sequencer.
// State encoding, requester count and requester index type.
package bus_grant_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/bus_grant_sequencer_rr_pick4.sv
// rr_pick4: combinational round-robin picker over 4 requesters.
// Ports: req_i requests, last_i last owner; winner_o, any_o.
module rr_pick4
  import bus_grant_pkg::*;
(
  input  logic [3:0] req_i,
  input  req_idx_t   last_i,
  output req_idx_t   winner_o,
  output logic       any_o
);

  req_idx_t idx;
  logic     found;

  // Scan starts one past the last owner and wraps,
  // so the last owner itself is checked last.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last_i + req_idx_t'(i);
      if (!found && req_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/bus_grant_sequencer.sv
// bus_grant_sequencer: round-robin bus arbiter driving a 2-to-4
// decoder (sel, enable_n) with turnaround gaps and a burst cap.
// Ports: clock, reset (sync, active high), req[3:0],
// lock (only with BUS_GRANT_LOCK_EN), sel[1:0], enable_n, busy.
module bus_grant_sequencer
  import bus_grant_pkg::*;
#(
  parameter int unsigned TURNAROUND_CYCLES = 1,
  parameter int unsigned MAX_HOLD          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
`ifdef BUS_GRANT_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] sel,
  output logic       enable_n,
  output logic       busy
);

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GAP_INIT  = 4'(TURNAROUND_CYCLES - 1);

  state_e     state_q, state_d;
  req_idx_t   sel_q, sel_d;
  req_idx_t   last_q, last_d;
  logic       en_n_q, en_n_d;
  logic       busy_q, busy_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gap_q, gap_d;

  req_idx_t   winner;
  logic       any_req;
  logic [3:0] other_req;
  logic       preempt;

  rr_pick4 u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign other_req = req & ~(4'b0001 << sel_q);

`ifdef BUS_GRANT_LOCK_EN
  assign preempt = (hold_q >= HOLD_LAST) &&
                   (|other_req) && !lock;
`else
  assign preempt = (hold_q >= HOLD_LAST) &&
                   (|other_req);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    en_n_d  = en_n_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        en_n_d = 1'b1;
        if (any_req) begin
          sel_d   = winner;
          en_n_d  = 1'b0;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        en_n_d = 1'b0;
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 8'd1;
        end
        if (!req[sel_q] || preempt) begin
          en_n_d  = 1'b1;
          last_d  = sel_q;
          gap_d   = GAP_INIT;
          state_d = GAP;
        end
      end
      GAP: begin
        en_n_d = 1'b1;
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (any_req) begin
          sel_d   = winner;
          en_n_d  = 1'b0;
          hold_d  = '0;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        en_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= 2'd3;
      en_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      en_n_q  <= en_n_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign sel      = sel_q;
  assign enable_n = en_n_q;
  assign busy     = busy_q;

endmodule

// File: doc/bus_grant_sequencer.md
Name: bus_grant_sequencer

Overview:
- Round-robin arbiter for 4 bus requesters sharing one bus.
- Drives the select pair and active-low enable of one half of a dual 2-to-4 decoder; the decoder's active-low outputs gate the 4 bus drivers' output enables.
- Guarantees no two drivers are ever enabled together.
- Inserts programmable dead (turnaround) cycles between grants.
- Caps burst length when other requesters are waiting.

Parameters:
- TURNAROUND_CYCLES, 1, dead cycles with enable_n high between consecutive grants; legal range 1..15.
- MAX_HOLD, 8, maximum grant length in cycles while another requester is pending; legal range 1..255.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  req[i] high = requester i wants the bus; level-sensitive, held for the whole transfer.
- sel  output  2  index of the granted requester; drives the decoder select pair.
- enable_n  output  1  active-low decoder enable; low = requester sel owns the bus.
- busy  output  1  high in GRANT and GAP states.

Behaviour:
- All outputs are registered.
- Reset:
  - state=IDLE, enable_n=1, sel=0, busy=0.
  - last=3, so requester 0 has top priority after reset.
  - hold_cnt=0, gap_cnt=0.
- Reset asserted mid-grant: enable_n=1 from the following edge; no partial state survives.
- Winner pick:
  - Scan from (last+1) mod 4 upward with wrap; first index with req high wins.
  - Scan is combinational on the current req.
- IDLE:
  - enable_n=1.
  - If any req is high at edge N: sel<=winner, enable_n<=0 at N, state<=GRANT, hold_cnt<=0.
  - Latency from req to grant is 1 cycle.
- GRANT:
  - enable_n=0; sel is frozen.
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Release condition: req[sel]==0, OR (hold_cnt>=MAX_HOLD-1 AND any other req high).
  - On release at edge N: enable_n<=1, last<=sel, gap_cnt<=TURNAROUND_CYCLES-1, state<=GAP.
  - MAX_HOLD reached with no other requester: grant continues indefinitely.
- GAP:
  - enable_n=1.
  - When gap_cnt>0: decrement.
  - When gap_cnt==0 and a req is high: pick winner, sel<=winner, enable_n<=0, state<=GRANT.
  - When gap_cnt==0 and no req: state<=IDLE.
  - Result: exactly TURNAROUND_CYCLES cycles of enable_n=1 between back-to-back grants.
- Invariant: sel changes only on an edge where enable_n is 1, or where enable_n goes 1->0 together with the new sel. sel never changes while enable_n is 0 (glitch-free decode).
- A requester dropping req during GAP or IDLE simply loses arbitration; there is no pending latch.
- Simultaneous requests: round-robin order guarantees each requester a grant within 3 other grants (no starvation).

Optional Feature:
- Macro: BUS_GRANT_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While lock=1 in GRANT, the MAX_HOLD pre-emption is suppressed; release happens only when req[sel] drops.
  - lock is ignored outside GRANT.
- Undefined:
  - Port is absent; pre-emption always applies.

Decomposition:
- Package bus_grant_pkg holds:
  - state enum: IDLE, GRANT, GAP, 2-bit encoding.
  - requester count constant NUM_REQ=4.
  - index typedef req_idx_t (2 bits).
- One natural sub-module: rr_pick4.
  - Combinational round-robin priority picker.
  - Inputs: req[3:0], last.
  - Outputs: winner, any.

Test Plan:
1. Reset, then req=4'b0001 at cycle 2 -> enable_n=0 and sel=0 at cycle 3; req falls at cycle 6 -> enable_n=1 at cycle 7 for exactly 1 cycle (TURNAROUND_CYCLES=1), then IDLE.
2. req=4'b1111 held constantly, MAX_HOLD=8 -> grants in order 0,1,2,3,0; each lasts 8 cycles, separated by 1 dead cycle; sel never changes while enable_n=0.
3. req=4'b0100 alone for 20 cycles -> a single continuous grant to 2 with no pre-emption; then req[1] rises -> release after the 8-cycle limit is already met, so enable_n=1 on the next edge and 1 is granted after the gap.
4. TURNAROUND_CYCLES=3, req=4'b0011 -> between the grant to 0 and the grant to 1, enable_n=1 for exactly 3 cycles.
5. Reset asserted during a grant to 3 -> enable_n=1 and sel=0 on the next edge; with req=4'b1000 still high after reset drops, 3 is re-granted 1 cycle later.
6. With BUS_GRANT_LOCK_EN defined, lock=1 and req=4'b0011 -> the grant to 0 lasts 20 cycles until req[0] drops; with lock=0 it is pre-empted at 8 cycles.
